ssd1306_ctrl_seq: RTL and testbench

- Sequencer sitting above the 4-wire SPI byte engine that drives the SSD1306 128x64 OLED.
- Generates the panel hardware reset pulse on RES, then streams a fixed 25-byte init command list.
- After init, on each refresh request, pushes the full 1 KiB framebuffer page by page through a valid/ready byte handshake.
- Framebuffer is an external synchronous-read RAM owned by the display subsystem.

---
 rtl/ssd1306_ctrl_seq_if.sv | 21 ++
 rtl/ssd1306_ctrl_seq.sv | 192 +++++++++++++++++++
 tb/tb_ssd1306_ctrl_seq.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd1306_ctrl_seq_if.sv
// Byte-stream and framebuffer-read bus between the SSD1306 sequencer
// (master) and the SPI byte engine / framebuffer RAM (slave side).
interface ssd1306_ctrl_seq_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       fb_rd_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_rdata;

  modport master (
    output tx_valid, tx_byte, tx_dc, fb_rd_en, fb_addr,
    input  tx_ready, fb_rdata
  );

  modport slave (
    input  tx_valid, tx_byte, tx_dc, fb_rd_en, fb_addr,
    output tx_ready, fb_rdata
  );
endinterface

// File: rtl/ssd1306_ctrl_seq.sv
// SSD1306 128x64 OLED sequencer: panel reset pulse, 25-byte init command
// list, then one full framebuffer push (page address commands + 128 data
// bytes per page) for every refresh request. Bytes leave through a
// valid/ready handshake towards the SPI byte engine.
module ssd1306_ctrl_seq #(
  parameter int RST_LOW_CYCLES  = 100000,
  parameter int RST_WAIT_CYCLES = 100000,
  parameter int PAGES           = 8,
  parameter int COLS            = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic refresh_req,
  output logic busy,
  output logic init_done,
  output logic oled_rst_n,
  ssd1306_ctrl_seq_if.master bus
);

  localparam logic [2:0] ST_RST_LOW  = 3'd0;
  localparam logic [2:0] ST_RST_WAIT = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_IDLE     = 3'd3;
  localparam logic [2:0] ST_PAGE_CMD = 3'd4;
  localparam logic [2:0] ST_FETCH    = 3'd5;
  localparam logic [2:0] ST_LOAD     = 3'd6;
  localparam logic [2:0] ST_SEND     = 3'd7;

  localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYCLES - 1);
  localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYCLES - 1);
  localparam logic [7:0]  COL_LAST      = 8'(COLS - 1);
  localparam logic [3:0]  PAGE_LAST     = 4'(PAGES - 1);
  localparam logic [4:0]  INIT_LAST     = 5'd24;

  // Panel power-up command list, sent in order with D/C low.
  localparam logic [7:0] INIT_ROM [0:24] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  logic [2:0]  state;
  logic [31:0] counter;
  logic [4:0]  idx;
  logic [3:0]  page;
  logic [7:0]  col;
  logic        pending;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        fb_rd_en;
  logic [9:0]  fb_addr;
  logic        xfer;

  assign bus.tx_valid = tx_valid;
  assign bus.tx_byte  = tx_byte;
  assign bus.tx_dc    = tx_dc;
  assign bus.fb_rd_en = fb_rd_en;
  assign bus.fb_addr  = fb_addr;

  // A byte leaves on every edge where the engine accepts the offered byte.
  assign xfer = tx_valid & bus.tx_ready;
  assign busy = (state != ST_IDLE);

  // Main sequencer: every state change and every byte/address update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST_LOW;
      counter    <= '0;
      idx        <= '0;
      page       <= '0;
      col        <= '0;
      pending    <= 1'b0;
      init_done  <= 1'b0;
      oled_rst_n <= 1'b0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
      tx_dc      <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
    end else begin
      // Requests outside IDLE coalesce into a single pending frame.
      if (state != ST_IDLE && refresh_req) begin
        pending <= 1'b1;
      end

      case (state)
        ST_RST_LOW: begin
          if (counter == RST_LOW_LAST) begin
            counter    <= '0;
            oled_rst_n <= 1'b1;
            state      <= ST_RST_WAIT;
          end else begin
            counter <= counter + 32'd1;
          end
        end

        ST_RST_WAIT: begin
          if (counter == RST_WAIT_LAST) begin
            counter  <= '0;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_byte  <= INIT_ROM[0];
            tx_dc    <= 1'b0;
            state    <= ST_INIT;
          end else begin
            counter <= counter + 32'd1;
          end
        end

        ST_INIT: begin
          if (xfer) begin
            if (idx == INIT_LAST) begin
              tx_valid  <= 1'b0;
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              // Next command is ready immediately: back-to-back transfer.
              idx     <= idx + 5'd1;
              tx_byte <= INIT_ROM[idx + 5'd1];
            end
          end
        end

        ST_IDLE: begin
          if (pending || refresh_req) begin
            pending  <= 1'b0;
            page     <= '0;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_byte  <= 8'hB0;
            tx_dc    <= 1'b0;
            state    <= ST_PAGE_CMD;
          end
        end

        ST_PAGE_CMD: begin
          if (xfer) begin
            if (idx == 5'd2) begin
              // Page address set; start reading column 0 of this page.
              tx_valid <= 1'b0;
              col      <= '0;
              fb_rd_en <= 1'b1;
              fb_addr  <= 10'(32'(page) * COLS);
              state    <= ST_FETCH;
            end else begin
              idx     <= idx + 5'd1;
              tx_byte <= (idx == 5'd0) ? 8'h00 : 8'h10;
            end
          end
        end

        ST_FETCH: begin
          // RAM samples the strobe on this edge; data arrives in LOAD.
          fb_rd_en <= 1'b0;
          state    <= ST_LOAD;
        end

        ST_LOAD: begin
          tx_byte  <= bus.fb_rdata;
          tx_dc    <= 1'b1;
          tx_valid <= 1'b1;
          state    <= ST_SEND;
        end

        ST_SEND: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            if (col != COL_LAST) begin
              col      <= col + 8'd1;
              fb_rd_en <= 1'b1;
              fb_addr  <= 10'(32'(page) * COLS + 32'(col) + 32'd1);
              state    <= ST_FETCH;
            end else if (page != PAGE_LAST) begin
              page     <= page + 4'd1;
              idx      <= '0;
              tx_valid <= 1'b1;
              tx_byte  <= {4'hB, page + 4'd1};
              tx_dc    <= 1'b0;
              state    <= ST_PAGE_CMD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_ctrl_seq.sv
// Bench for ssd1306_ctrl_seq: reset/init timing, init under backpressure,
// table of refresh scenarios against a byte-stream reference model, and
// hand-written corner sequences (frame-end request, early request, stall,
// reset mid-frame).
module tb_ssd1306_ctrl_seq;
  localparam int RL = 10;
  localparam int RW = 10;
  localparam int PG = 8;
  localparam int CL = 128;
  localparam int FRAME_LEN = PG * (3 + CL);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic refresh_req;
  logic busy;
  logic init_done;
  logic oled_rst_n;

  ssd1306_ctrl_seq_if bus ();

  ssd1306_ctrl_seq #(
    .RST_LOW_CYCLES (RL),
    .RST_WAIT_CYCLES(RW),
    .PAGES          (PG),
    .COLS           (CL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_req(refresh_req),
    .busy       (busy),
    .init_done  (init_done),
    .oled_rst_n (oled_rst_n),
    .bus        (bus)
  );

  // Framebuffer RAM model with registered read.
  logic [7:0] fb [1024];
  always @(posedge clk) begin
    if (bus.fb_rd_en === 1'b1) bus.fb_rdata <= fb[bus.fb_addr];
  end

  logic [7:0] rom [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [8:0] obs_q [$];  // {dc, byte} as observed on the bus
  logic [8:0] exp_q [$];  // {dc, byte} from the reference model

  logic       snap_valid = 1'b0;
  logic       snap_ready = 1'b0;
  logic       snap_rst   = 1'b1;
  logic [7:0] snap_byte  = 8'h00;
  logic       snap_dc    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records transfers of the previous edge, checks that a stalled
  // byte is held, then drives tx_ready for the coming edge.
  always @(negedge clk) begin
    #1;
    if (snap_valid && snap_ready && !snap_rst) begin
      obs_q.push_back({snap_dc, snap_byte});
    end else if (snap_valid && !snap_ready && !snap_rst) begin
      n_cmp++;
      if (bus.tx_valid !== 1'b1 || bus.tx_byte !== snap_byte || bus.tx_dc !== snap_dc) begin
        n_bad++;
        $display("FAIL hold_stable: got valid=%0b byte=%02h dc=%0b expected valid=1 byte=%02h dc=%0b",
                 bus.tx_valid, bus.tx_byte, bus.tx_dc, snap_byte, snap_dc);
      end
    end
    case (ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = 1'($urandom_range(0, 1));
      default: bus.tx_ready = 1'b0;
    endcase
    snap_valid = (bus.tx_valid === 1'b1);
    snap_ready = bus.tx_ready;
    snap_rst   = rst;
    snap_byte  = bus.tx_byte;
    snap_dc    = bus.tx_dc;
  end

  // Reference model: the byte stream the panel must receive.
  task automatic push_init();
    for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, rom[i]});
  endtask

  task automatic push_frame();
    for (int p = 0; p < PG; p++) begin
      exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h10});
      for (int c = 0; c < CL; c++) exp_q.push_back({1'b1, fb[p * CL + c]});
    end
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s[%0d]: got dc=%0b byte=%02h expected dc=%0b byte=%02h",
                 name, i, obs_q[i][8], obs_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
        break;
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_req();
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_init(input string name, input int budget);
    int n = 0;
    while (init_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_init_timeout"}, 32'(init_done === 1'b1), 1);
    #2;
  endtask

  // Idle means busy low on three consecutive samples (a pending frame
  // leaves IDLE after a single cycle).
  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    int idle = 0;
    while (idle < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) idle++;
      else idle = 0;
    end
    check({name, "_idle_timeout"}, 32'(idle >= 3), 1);
    #2;
  endtask

  task automatic wait_obs(input string name, input int target, input int budget);
    int n = 0;
    while (obs_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_progress_timeout"}, 32'(obs_q.size() >= target), 1);
  endtask

  typedef struct {
    string name;
    int    ready_mode;
    int    n_req;
    int    gap;
    int    exp_frames;
    bit    ramp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cnt;
    int sz;
    logic [7:0] held_byte;

    vecs[0] = '{name: "frame_ramp",    ready_mode: 0, n_req: 1, gap: 0,   exp_frames: 1, ramp: 1'b1};
    vecs[1] = '{name: "frame_rand_bp", ready_mode: 1, n_req: 1, gap: 0,   exp_frames: 1, ramp: 1'b0};
    vecs[2] = '{name: "triple_req",    ready_mode: 0, n_req: 3, gap: 400, exp_frames: 2, ramp: 1'b0};
    vecs[3] = '{name: "double_req_bp", ready_mode: 1, n_req: 2, gap: 1,   exp_frames: 2, ramp: 1'b0};

    for (int i = 0; i < 1024; i++) fb[i] = 8'(i);
    rst = 1'b1;
    refresh_req = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_oled_rst_n", 32'(oled_rst_n), 0);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_tx_byte", 32'(bus.tx_byte), 0);
    check("rst_tx_dc", 32'(bus.tx_dc), 0);
    check("rst_fb_rd_en", 32'(bus.fb_rd_en), 0);
    check("rst_fb_addr", 32'(bus.fb_addr), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_init_done", 32'(init_done), 0);

    // Reset pulse and init timing with tx_ready held high.
    obs_q.delete();
    rst = 1'b0;
    cnt = 0;
    while (oled_rst_n === 1'b0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("rst_low_cycles", cnt, RL);
    cnt = 0;
    while (bus.tx_valid !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("first_valid_delay", cnt, RW);
    check("first_byte", 32'(bus.tx_byte), 32'h AE);
    check("first_dc", 32'(bus.tx_dc), 0);
    wait_init("init", 500);
    check("init_byte_count", obs_q.size(), 25);
    check("init_busy_low", 32'(busy), 0);
    push_init();
    compare_stream("init");

    // Init under random backpressure.
    ready_mode = 1;
    do_reset();
    wait_init("init_bp", 2000);
    push_init();
    compare_stream("init_bp");

    // Table of refresh scenarios.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 1024; i++) fb[i] = vecs[v].ramp ? 8'(i) : 8'($urandom);
      ready_mode = vecs[v].ready_mode;
      for (int k = 0; k < vecs[v].n_req; k++) begin
        pulse_req();
        repeat (vecs[v].gap) @(negedge clk);
      end
      wait_idle(vecs[v].name, 20000);
      check({vecs[v].name, "_busy_end"}, 32'(busy), 0);
      for (int f = 0; f < vecs[v].exp_frames; f++) push_frame();
      compare_stream(vecs[v].name);
    end

    // Request in the same cycle the frame's last byte transfers.
    ready_mode = 0;
    for (int i = 0; i < 1024; i++) fb[i] = 8'($urandom);
    pulse_req();
    cnt = 0;
    while (!(bus.tx_valid === 1'b1 && obs_q.size() == FRAME_LEN - 1) && cnt < 10000) begin
      @(negedge clk);
      cnt++;
    end
    check("frame_end_reach", 32'(cnt < 10000), 1);
    pulse_req();
    wait_idle("frame_end_req", 10000);
    push_frame();
    push_frame();
    compare_stream("frame_end_req");

    // Request during RST_WAIT is served right after init.
    do_reset();
    cnt = 0;
    while (oled_rst_n !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    pulse_req();
    wait_init("early_req", 500);
    wait_idle("early_req", 10000);
    push_init();
    push_frame();
    compare_stream("early_req");

    // Stall: tx_ready low freezes the offered byte.
    ready_mode = 1;
    pulse_req();
    wait_obs("stall", 200, 5000);
    cnt = 0;
    while (bus.tx_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    ready_mode = 2;
    held_byte = bus.tx_byte;
    #2;
    sz = obs_q.size();
    repeat (50) @(negedge clk);
    check("stall_valid", 32'(bus.tx_valid), 1);
    check("stall_byte", 32'(bus.tx_byte), 32'(held_byte));
    check("stall_busy", 32'(busy), 1);
    #2;
    check("stall_no_xfer", obs_q.size(), sz);
    ready_mode = 0;
    wait_idle("stall", 10000);
    push_frame();
    compare_stream("stall");

    // Reset during page 3 data, with a request pending.
    pulse_req();
    wait_obs("rst_mid", 3 * (3 + CL) + 10, 5000);
    pulse_req();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_mid_oled_rst_n", 32'(oled_rst_n), 0);
    check("rst_mid_init_done", 32'(init_done), 0);
    check("rst_mid_busy", 32'(busy), 1);
    @(negedge clk);
    obs_q.delete();
    rst = 1'b0;
    wait_init("rst_mid", 500);
    wait_idle("rst_mid", 5000);
    push_init();
    compare_stream("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
